// File: rtl/wb_arbiter_2m_pkg.sv
// Shared definitions for the 2-master Wishbone arbiter.
// Contents: FSM state encodings (which double as the one-hot grant vector),
// the arbitration mode constants, the master identifier enum, and the
// owner-selection function used when the arbiter is idle.
package wb_arbiter_2m_pkg;

  // State encodings. The state register is exported directly as grant_o.
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_OWN0 = 2'b01;
  localparam logic [1:0] ST_OWN1 = 2'b10;

  // Arbitration modes.
  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  typedef enum logic {
    MST_0 = 1'b0,
    MST_1 = 1'b1
  } master_e;

  // Chooses the next owner from IDLE. On a tie, fixed priority always
  // picks M0; round-robin picks the master that did not own the port last.
  function automatic logic [1:0] pick_owner(input logic    req0,
                                            input logic    req1,
                                            input logic    rr_mode,
                                            input master_e rr_last);
    logic [1:0] owner;
    if (req0 && req1) begin
      if (rr_mode && (rr_last == MST_0)) begin
        owner = ST_OWN1;
      end else begin
        owner = ST_OWN0;
      end
    end else if (req0) begin
      owner = ST_OWN0;
    end else if (req1) begin
      owner = ST_OWN1;
    end else begin
      owner = ST_IDLE;
    end
    return owner;
  endfunction

endpackage

// File: rtl/wb_arb_wdt.sv
// Ack-wait watchdog for wb_arbiter_2m (built only with OSIRIS_ARB_TIMEOUT_EN).
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   clr       : clears the count (arbiter idle, or slave ack seen)
//   run       : owner is strobing and the slave has not acked this cycle
//   expire    : high during the TIMEOUT-th consecutive stalled cycle
module wb_arb_wdt #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT + 1);
  // The count reaches TIMEOUT-1 during the TIMEOUT-th stalled cycle, so
  // expire fires in that same cycle rather than one cycle late.
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_r;

  assign expire = run & (cnt_r == LIMIT);

  // Stall counter: cleared on idle/ack, advances on each stalled cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {CW{1'b0}};
    end else if (clr) begin
      cnt_r <= {CW{1'b0}};
    end else if (run && !expire) begin
      cnt_r <= cnt_r + CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/wb_arbiter_2m.sv
// 2-master / 1-slave Wishbone classic arbiter for the shared memory port.
// M0 = UART bridge (load/debug), M1 = core-side memory master.
// Grant is registered (one cycle latency from IDLE); the datapath mux is
// combinational so ack/data reach the owner with zero added latency. Only
// the owner ever sees ack, err or read data.
// Optional feature: define OSIRIS_ARB_TIMEOUT_EN to add an ack-wait watchdog
// (TIMEOUT stalled cycles -> err_o pulse to owner, slave cycle dropped,
// return to IDLE). Without it err_o is tied low and the arbiter waits forever.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   m0_wb_* / m1_wb_*                 master-side Wishbone (cyc/stb/we/adr/dat in,
//                                     dat/ack/err out)
//   s_wb_*                            slave-side Wishbone (cyc/stb/we/adr/dat out,
//                                     dat/ack in)
//   grant_o                           one-hot owner {M1,M0}, 2'b00 = idle
module wb_arbiter_2m
  import wb_arbiter_2m_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ARB_MODE   = 0,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_wb_cyc_i,
  input  logic                  m0_wb_stb_i,
  input  logic                  m0_wb_we_i,
  input  logic [ADDR_WIDTH-1:0] m0_wb_adr_i,
  input  logic [DATA_WIDTH-1:0] m0_wb_dat_i,
  output logic [DATA_WIDTH-1:0] m0_wb_dat_o,
  output logic                  m0_wb_ack_o,
  output logic                  m0_wb_err_o,
  input  logic                  m1_wb_cyc_i,
  input  logic                  m1_wb_stb_i,
  input  logic                  m1_wb_we_i,
  input  logic [ADDR_WIDTH-1:0] m1_wb_adr_i,
  input  logic [DATA_WIDTH-1:0] m1_wb_dat_i,
  output logic [DATA_WIDTH-1:0] m1_wb_dat_o,
  output logic                  m1_wb_ack_o,
  output logic                  m1_wb_err_o,
  output logic                  s_wb_cyc_o,
  output logic                  s_wb_stb_o,
  output logic                  s_wb_we_o,
  output logic [ADDR_WIDTH-1:0] s_wb_adr_o,
  output logic [DATA_WIDTH-1:0] s_wb_dat_o,
  input  logic [DATA_WIDTH-1:0] s_wb_dat_i,
  input  logic                  s_wb_ack_i,
  output logic [1:0]            grant_o
);

  localparam logic RR_EN = (ARB_MODE == ARB_RR) ? 1'b1 : 1'b0;

  logic [1:0] state_r;
  logic [1:0] state_nxt_s;
  master_e    rr_last_r;
  logic       req0_s;
  logic       req1_s;
  logic       expire_s;

  assign req0_s  = m0_wb_cyc_i & m0_wb_stb_i;
  assign req1_s  = m1_wb_cyc_i & m1_wb_stb_i;
  assign grant_o = state_r;

`ifdef OSIRIS_ARB_TIMEOUT_EN
  logic wdt_clr_s;
  logic wdt_run_s;

  // Count only genuine stalls: the owner is strobing and no ack came back.
  assign wdt_clr_s = (state_r == ST_IDLE) | s_wb_ack_i;
  assign wdt_run_s = (((state_r == ST_OWN0) & m0_wb_stb_i) |
                      ((state_r == ST_OWN1) & m1_wb_stb_i)) & ~s_wb_ack_i;

  wb_arb_wdt #(
    .TIMEOUT (TIMEOUT)
  ) u_wdt (
    .clk    (clk),
    .rst    (rst),
    .clr    (wdt_clr_s),
    .run    (wdt_run_s),
    .expire (expire_s)
  );
`else
  localparam int unused_timeout = TIMEOUT;
  assign expire_s = 1'b0;
`endif

  // Next-state logic: grant only from IDLE, hold while the owner keeps cyc.
  // Release always passes through IDLE, giving one dead cycle between owners.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        state_nxt_s = pick_owner(req0_s, req1_s, RR_EN, rr_last_r);
      end
      ST_OWN0: begin
        if (!m0_wb_cyc_i || expire_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_OWN0;
        end
      end
      ST_OWN1: begin
        if (!m1_wb_cyc_i || expire_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_OWN1;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register and last-owner memory; rr_last starts at M1 so M0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      rr_last_r <= MST_1;
    end else begin
      state_r <= state_nxt_s;
      if ((state_r == ST_IDLE) && (state_nxt_s == ST_OWN0)) begin
        rr_last_r <= MST_0;
      end else if ((state_r == ST_IDLE) && (state_nxt_s == ST_OWN1)) begin
        rr_last_r <= MST_1;
      end else begin
        rr_last_r <= rr_last_r;
      end
    end
  end

  // Datapath mux: owner drives the slave, slave response goes to owner only.
  // A watchdog expiry drops the slave cycle in the same cycle it reports err.
  always_comb begin
    s_wb_cyc_o  = 1'b0;
    s_wb_stb_o  = 1'b0;
    s_wb_we_o   = 1'b0;
    s_wb_adr_o  = {ADDR_WIDTH{1'b0}};
    s_wb_dat_o  = {DATA_WIDTH{1'b0}};
    m0_wb_dat_o = {DATA_WIDTH{1'b0}};
    m0_wb_ack_o = 1'b0;
    m0_wb_err_o = 1'b0;
    m1_wb_dat_o = {DATA_WIDTH{1'b0}};
    m1_wb_ack_o = 1'b0;
    m1_wb_err_o = 1'b0;
    case (state_r)
      ST_OWN0: begin
        s_wb_cyc_o  = m0_wb_cyc_i & ~expire_s;
        s_wb_stb_o  = m0_wb_stb_i & ~expire_s;
        s_wb_we_o   = m0_wb_we_i;
        s_wb_adr_o  = m0_wb_adr_i;
        s_wb_dat_o  = m0_wb_dat_i;
        m0_wb_dat_o = s_wb_dat_i;
        m0_wb_ack_o = s_wb_ack_i;
        m0_wb_err_o = expire_s;
      end
      ST_OWN1: begin
        s_wb_cyc_o  = m1_wb_cyc_i & ~expire_s;
        s_wb_stb_o  = m1_wb_stb_i & ~expire_s;
        s_wb_we_o   = m1_wb_we_i;
        s_wb_adr_o  = m1_wb_adr_i;
        s_wb_dat_o  = m1_wb_dat_i;
        m1_wb_dat_o = s_wb_dat_i;
        m1_wb_ack_o = s_wb_ack_i;
        m1_wb_err_o = expire_s;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Directed testbench for wb_arbiter_2m. Two arbiters are instantiated side by
// side: index 0 uses fixed priority, index 1 round-robin, both TIMEOUT=8.
// Each has its own simple slave (acks one cycle after a strobe, small memory).
// Expectations for the watchdog scenario follow OSIRIS_ARB_TIMEOUT_EN.
module tb_wb_arbiter_2m;

`ifdef OSIRIS_ARB_TIMEOUT_EN
  localparam int         EXP_ERR_CYC = 8;
  localparam logic [1:0] EXP_G9      = 2'b00;
`else
  localparam int         EXP_ERR_CYC = -1;
  localparam logic [1:0] EXP_G9      = 2'b10;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        m_cyc  [2][2];
  logic        m_stb  [2][2];
  logic        m_we   [2][2];
  logic [31:0] m_adr  [2][2];
  logic [31:0] m_wdat [2][2];
  logic [31:0] m_rdat [2][2];
  logic        m_ack  [2][2];
  logic        m_err  [2][2];
  logic        s_cyc  [2];
  logic        s_stb  [2];
  logic        s_we   [2];
  logic [31:0] s_adr  [2];
  logic [31:0] s_wdat [2];
  logic [31:0] s_rdat [2];
  logic        s_ack  [2];
  logic [1:0]  grant  [2];

  logic        slv_ack   [2];
  logic        ack_en    [2];
  logic        force_ack [2];
  logic [31:0] rd_data   [2];
  logic [31:0] mem       [2][4];

  int          order_q [2][$];
  int          gap_q   [2][$];
  int          switch_err [2];
  int          idle_run [2];
  logic [1:0]  prev_g  [2];

  int n_cmp = 0;
  int n_bad = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    wb_arbiter_2m #(
      .DATA_WIDTH (32),
      .ADDR_WIDTH (32),
      .ARB_MODE   (g),
      .TIMEOUT    (8)
    ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .m0_wb_cyc_i (m_cyc[g][0]),
      .m0_wb_stb_i (m_stb[g][0]),
      .m0_wb_we_i  (m_we[g][0]),
      .m0_wb_adr_i (m_adr[g][0]),
      .m0_wb_dat_i (m_wdat[g][0]),
      .m0_wb_dat_o (m_rdat[g][0]),
      .m0_wb_ack_o (m_ack[g][0]),
      .m0_wb_err_o (m_err[g][0]),
      .m1_wb_cyc_i (m_cyc[g][1]),
      .m1_wb_stb_i (m_stb[g][1]),
      .m1_wb_we_i  (m_we[g][1]),
      .m1_wb_adr_i (m_adr[g][1]),
      .m1_wb_dat_i (m_wdat[g][1]),
      .m1_wb_dat_o (m_rdat[g][1]),
      .m1_wb_ack_o (m_ack[g][1]),
      .m1_wb_err_o (m_err[g][1]),
      .s_wb_cyc_o  (s_cyc[g]),
      .s_wb_stb_o  (s_stb[g]),
      .s_wb_we_o   (s_we[g]),
      .s_wb_adr_o  (s_adr[g]),
      .s_wb_dat_o  (s_wdat[g]),
      .s_wb_dat_i  (s_rdat[g]),
      .s_wb_ack_i  (s_ack[g]),
      .grant_o     (grant[g])
    );
  end

  assign s_ack[0]  = slv_ack[0] | force_ack[0];
  assign s_ack[1]  = slv_ack[1] | force_ack[1];
  assign s_rdat[0] = rd_data[0];
  assign s_rdat[1] = rd_data[1];

  // Slave models: ack one cycle after a strobe, capture writes on that edge.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        slv_ack[i] <= 1'b0;
      end else begin
        slv_ack[i] <= s_cyc[i] & s_stb[i] & ~slv_ack[i] & ack_en[i];
        if (s_cyc[i] & s_stb[i] & s_we[i] & ~slv_ack[i] & ack_en[i])
          mem[i][s_adr[i][3:2]] <= s_wdat[i];
      end
    end
  end

  // Grant monitor: logs owner order, idle gap before each grant, direct switches.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        prev_g[i]   <= 2'b00;
        idle_run[i] <= 0;
      end else begin
        if (grant[i] != 2'b00 && grant[i] != prev_g[i]) begin
          order_q[i].push_back(grant[i] == 2'b01 ? 0 : (grant[i] == 2'b10 ? 1 : 3));
          gap_q[i].push_back(idle_run[i]);
        end
        if (prev_g[i] != 2'b00 && grant[i] != 2'b00 && grant[i] != prev_g[i])
          switch_err[i] <= switch_err[i] + 1;
        idle_run[i] <= (grant[i] == 2'b00) ? idle_run[i] + 1 : 0;
        prev_g[i]   <= grant[i];
      end
    end
  end

  // Owner sequence from index start as decimal digits (M0 -> 1, M1 -> 2).
  function automatic int seq_code(input int i, input int start);
    int code = 0;
    for (int k = start; k < order_q[i].size(); k++) code = code * 10 + order_q[i][k] + 1;
    return code;
  endfunction

  task automatic set_req(input int i, input int m, input logic on, input logic we,
                         input logic [31:0] adr);
    m_cyc[i][m] = on;
    m_stb[i][m] = on;
    m_we[i][m]  = we;
    m_adr[i][m] = adr;
  endtask

  // Master transaction: n beats under one cyc, bounded wait per beat.
  task automatic burst(input int i, input int m, input int n, input logic we,
                       input logic [31:0] base, input logic [31:0] d0,
                       output logic [31:0] last_rd, output bit ok);
    int w;
    ok = 1'b1;
    last_rd = 32'h0;
    for (int b = 0; b < n; b++) begin
      m_cyc[i][m]  = 1'b1;
      m_stb[i][m]  = 1'b1;
      m_we[i][m]   = we;
      m_adr[i][m]  = base + 32'(4 * b);
      m_wdat[i][m] = d0 + 32'(b);
      w = 0;
      do begin
        @(negedge clk);
        w++;
      end while (!m_ack[i][m] && w < 60);
      if (!m_ack[i][m]) ok = 1'b0;
      last_rd = m_rdat[i][m];
    end
    m_cyc[i][m] = 1'b0;
    m_stb[i][m] = 1'b0;
    m_we[i][m]  = 1'b0;
  endtask

  // Both masters run two single-beat transfers, re-requesting after one idle cycle.
  task automatic two_each(input int i, output bit ok);
    bit ok_a, ok_b, ok_c, ok_d;
    logic [31:0] rd;
    fork
      begin
        burst(i, 0, 1, 1'b0, 32'h0, 32'h0, rd, ok_a);
        @(negedge clk);
        burst(i, 0, 1, 1'b0, 32'h0, 32'h0, rd, ok_b);
      end
      begin
        burst(i, 1, 1, 1'b0, 32'h4, 32'h0, rd, ok_c);
        @(negedge clk);
        burst(i, 1, 1, 1'b0, 32'h4, 32'h0, rd, ok_d);
      end
    join
    ok = ok_a & ok_b & ok_c & ok_d;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      set_req(i, 0, 1'b1, 1'b0, 32'h0);
      set_req(i, 1, 1'b1, 1'b0, 32'h0);
    end
    repeat (2) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        n_cmp++;
        if (grant[i] !== 2'b00) begin
          n_bad++; $display("FAIL reset_grant[%0d]: got %b want 00", i, grant[i]);
        end
        n_cmp++;
        if ({s_cyc[i], s_stb[i], s_we[i]} !== 3'b000 || s_adr[i] !== 32'h0) begin
          n_bad++; $display("FAIL reset_slave[%0d]: cyc/stb/we %b%b%b adr %h want 0",
                            i, s_cyc[i], s_stb[i], s_we[i], s_adr[i]);
        end
        n_cmp++;
        if ({m_ack[i][0], m_ack[i][1], m_err[i][0], m_err[i][1]} !== 4'b0000) begin
          n_bad++; $display("FAIL reset_ack_err[%0d]: got %b%b%b%b want 0000",
                            i, m_ack[i][0], m_ack[i][1], m_err[i][0], m_err[i][1]);
        end
      end
    end
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (grant[i] !== 2'b01) begin
        n_bad++; $display("FAIL first_grant[%0d]: got %b want 01", i, grant[i]);
      end
    end
    // Reset in the middle of M0's ownership drops the slave cycle.
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (grant[0] !== 2'b00 || s_cyc[0] !== 1'b0) begin
      n_bad++; $display("FAIL midreset: grant %b cyc %b want 00 0", grant[0], s_cyc[0]);
    end
    for (int i = 0; i < 2; i++) begin
      set_req(i, 0, 1'b0, 1'b0, 32'h0);
      set_req(i, 1, 1'b0, 1'b0, 32'h0);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_read();
    rd_data[0] = 32'hDEADBEEF;
    set_req(0, 1, 1'b1, 1'b0, 32'h10);
    @(negedge clk);
    n_cmp++;
    if (grant[0] !== 2'b10 || s_cyc[0] !== 1'b1 || s_stb[0] !== 1'b1 || s_adr[0] !== 32'h10) begin
      n_bad++; $display("FAIL single_grant: grant %b cyc %b stb %b adr %h want 10 1 1 00000010",
                        grant[0], s_cyc[0], s_stb[0], s_adr[0]);
    end
    n_cmp++;
    if (m_ack[0][1] !== 1'b0) begin
      n_bad++; $display("FAIL single_early_ack: got %b want 0", m_ack[0][1]);
    end
    @(negedge clk);
    n_cmp++;
    if (m_ack[0][1] !== 1'b1 || m_rdat[0][1] !== 32'hDEADBEEF) begin
      n_bad++; $display("FAIL single_m1_data: ack %b dat %h want 1 deadbeef",
                        m_ack[0][1], m_rdat[0][1]);
    end
    n_cmp++;
    if (m_ack[0][0] !== 1'b0 || m_rdat[0][0] !== 32'h0) begin
      n_bad++; $display("FAIL single_m0_quiet: ack %b dat %h want 0 0", m_ack[0][0], m_rdat[0][0]);
    end
    set_req(0, 1, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    n_cmp++;
    if (grant[0] !== 2'b00) begin
      n_bad++; $display("FAIL single_release: got %b want 00", grant[0]);
    end
    @(negedge clk);
  endtask

  task automatic test_fixed_priority();
    bit ok0, ok1;
    logic [31:0] rd, rd1;
    rd_data[0] = 32'h12345678;
    for (int r = 0; r < 2; r++) begin
      int start = order_q[0].size();
      fork
        burst(0, 0, 1, 1'b1, 32'h0, 32'hCAFEF00D, rd, ok0);
        burst(0, 1, 1, 1'b0, 32'h4, 32'h0, rd1, ok1);
      join
      repeat (2) @(negedge clk);
      n_cmp++;
      if (seq_code(0, start) !== 12 || !(ok0 && ok1)) begin
        n_bad++; $display("FAIL fixed_order_r%0d: got %0d ok %0d%0d want 12 ok 11",
                          r, seq_code(0, start), ok0, ok1);
      end
      n_cmp++;
      if (gap_q[0][start + 1] !== 1) begin
        n_bad++; $display("FAIL fixed_dead_cycle_r%0d: got %0d want 1", r, gap_q[0][start + 1]);
      end
      n_cmp++;
      if (mem[0][0] !== 32'hCAFEF00D || rd1 !== 32'h12345678) begin
        n_bad++; $display("FAIL fixed_data_r%0d: mem %h rd %h want cafef00d 12345678",
                          r, mem[0][0], rd1);
      end
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    logic [31:0] rd;
    int start;
    start = order_q[1].size();
    two_each(1, ok);
    n_cmp++;
    if (seq_code(1, start) !== 1212 || !ok) begin
      n_bad++; $display("FAIL rr_from_reset: got %0d ok %0d want 1212 ok 1", seq_code(1, start), ok);
    end
    burst(1, 0, 1, 1'b0, 32'h0, 32'h0, rd, ok);
    repeat (2) @(negedge clk);
    start = order_q[1].size();
    two_each(1, ok);
    n_cmp++;
    if (seq_code(1, start) !== 2121 || !ok) begin
      n_bad++; $display("FAIL rr_after_m0: got %0d ok %0d want 2121 ok 1", seq_code(1, start), ok);
    end
    start = order_q[0].size();
    two_each(0, ok);
    n_cmp++;
    if (seq_code(0, start) !== 1122 || !ok) begin
      n_bad++; $display("FAIL fixed_starve: got %0d ok %0d want 1122 ok 1", seq_code(0, start), ok);
    end
  endtask

  task automatic test_block_transfer();
    bit ok0, ok1;
    logic [31:0] rd;
    int start = order_q[0].size();
    fork
      burst(0, 0, 3, 1'b1, 32'h0, 32'h000000A0, rd, ok0);
      begin
        repeat (2) @(negedge clk);
        burst(0, 1, 1, 1'b0, 32'h4, 32'h0, rd, ok1);
      end
    join
    repeat (2) @(negedge clk);
    n_cmp++;
    if (seq_code(0, start) !== 12 || !(ok0 && ok1)) begin
      n_bad++; $display("FAIL block_order: got %0d ok %0d%0d want 12 ok 11",
                        seq_code(0, start), ok0, ok1);
    end
    n_cmp++;
    if (mem[0][0] !== 32'hA0 || mem[0][1] !== 32'hA1 || mem[0][2] !== 32'hA2) begin
      n_bad++; $display("FAIL block_data: got %h %h %h want a0 a1 a2", mem[0][0], mem[0][1], mem[0][2]);
    end
    n_cmp++;
    if (switch_err[0] !== 0 || switch_err[1] !== 0) begin
      n_bad++; $display("FAIL no_direct_switch: got %0d %0d want 0 0", switch_err[0], switch_err[1]);
    end
  endtask

  task automatic test_stb_gap();
    int w = 0;
    set_req(0, 0, 1'b1, 1'b0, 32'h8);
    do begin
      @(negedge clk);
      w++;
    end while (!m_ack[0][0] && w < 20);
    m_stb[0][0] = 1'b0;
    set_req(0, 1, 1'b1, 1'b0, 32'h4);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_cmp++;
      if (grant[0] !== 2'b01 || s_cyc[0] !== 1'b1 || s_stb[0] !== 1'b0 || m_ack[0][0] !== 1'b0) begin
        n_bad++; $display("FAIL stb_gap_%0d: grant %b cyc %b stb %b ack %b want 01 1 0 0",
                          k, grant[0], s_cyc[0], s_stb[0], m_ack[0][0]);
      end
    end
    m_cyc[0][0] = 1'b0;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!m_ack[0][1] && w < 20);
    n_cmp++;
    if (m_ack[0][1] !== 1'b1 || grant[0] !== 2'b10) begin
      n_bad++; $display("FAIL stb_gap_handover: ack %b grant %b want 1 10", m_ack[0][1], grant[0]);
    end
    set_req(0, 1, 1'b0, 1'b0, 32'h0);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_stray_ack();
    int w = 0;
    force_ack[0] = 1'b1;
    #1;
    n_cmp++;
    if (grant[0] !== 2'b00 || m_ack[0][0] !== 1'b0 || m_ack[0][1] !== 1'b0) begin
      n_bad++; $display("FAIL idle_ack: grant %b acks %b%b want 00 00", grant[0], m_ack[0][0], m_ack[0][1]);
    end
    @(negedge clk);
    set_req(0, 0, 1'b1, 1'b0, 32'h0);
    do begin
      @(negedge clk);
      w++;
    end while (grant[0] !== 2'b01 && w < 20);
    n_cmp++;
    if (m_ack[0][0] !== 1'b1 || m_ack[0][1] !== 1'b0) begin
      n_bad++; $display("FAIL nonowner_ack: acks m0 %b m1 %b want 1 0", m_ack[0][0], m_ack[0][1]);
    end
    force_ack[0] = 1'b0;
    set_req(0, 0, 1'b0, 1'b0, 32'h0);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_timeout();
    int first_err = -1;
    logic err_scyc = 1'b0;
    logic m0_err_seen = 1'b0;
    logic [1:0] g9 = 2'b11;
    ack_en[0] = 1'b0;
    set_req(0, 1, 1'b1, 1'b0, 32'h20);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (m_err[0][1] && first_err < 0) begin
        first_err = k;
        err_scyc  = s_cyc[0] | s_stb[0];
      end
      if (m_err[0][0]) m0_err_seen = 1'b1;
      if (k == 9) g9 = grant[0];
    end
    n_cmp++;
    if (first_err !== EXP_ERR_CYC) begin
      n_bad++; $display("FAIL timeout_err_cycle: got %0d want %0d", first_err, EXP_ERR_CYC);
    end
    n_cmp++;
    if (g9 !== EXP_G9) begin
      n_bad++; $display("FAIL timeout_grant: got %b want %b", g9, EXP_G9);
    end
    n_cmp++;
    if (err_scyc !== 1'b0 || m0_err_seen !== 1'b0) begin
      n_bad++; $display("FAIL timeout_side: slave cyc/stb %b m0_err %b want 0 0", err_scyc, m0_err_seen);
    end
    set_req(0, 1, 1'b0, 1'b0, 32'h0);
    ack_en[0] = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (grant[0] !== 2'b00) begin
      n_bad++; $display("FAIL timeout_release: got %b want 00", grant[0]);
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      ack_en[i]    = 1'b1;
      force_ack[i] = 1'b0;
      rd_data[i]   = 32'h0;
      for (int m = 0; m < 2; m++) begin
        set_req(i, m, 1'b0, 1'b0, 32'h0);
        m_wdat[i][m] = 32'h0;
      end
    end
    test_reset();
    test_single_read();
    test_fixed_priority();
    test_round_robin();
    test_block_transfer();
    test_stb_gap();
    test_stray_ack();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule
